// File: rtl/regfile_loader_pkg.sv
// Shared constants for the register-file loader: default geometry and FSM state encodings.
`default_nettype none

package regfile_loader_pkg;

   localparam int DATATYPE_SIZE = 8;
   localparam int ADDR_WIDTH    = 6;
   localparam int DEPTH         = 2 ** ADDR_WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_PAD  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/regfile_loader_if.sv
// Stream, consumer and storage-port signals of the register-file loader.
`default_nettype none

interface regfile_loader_if
   import regfile_loader_pkg::*;
#(
   parameter int DW = DATATYPE_SIZE,
   parameter int AW = ADDR_WIDTH
) ();

   logic          start;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_wr_data;
   logic          rf_we;
   logic          busy;
   logic          done;
   logic [AW:0]   count;

   // Loader side.
   modport slave (
      input  start, s_valid, s_data, s_last, rd_addr,
      output s_ready, rf_addr, rf_wr_data, rf_we, busy, done, count
   );

   // Producer / consumer / storage side.
   modport master (
      output start, s_valid, s_data, s_last, rd_addr,
      input  s_ready, rf_addr, rf_wr_data, rf_we, busy, done, count
   );

endinterface

`default_nettype wire

// File: rtl/regfile_loader.sv
// Fills a 2**ADDR_WIDTH-entry register file from a valid/ready byte stream, then hands the address port back.
// Optional REGFILE_LOADER_ZERO_PAD_EN: an early s_last zero-fills the remaining entries before DONE.
`default_nettype none

module regfile_loader
   import regfile_loader_pkg::*;
#(
   parameter int DATATYPE_SIZE = regfile_loader_pkg::DATATYPE_SIZE,
   parameter int ADDR_WIDTH    = regfile_loader_pkg::ADDR_WIDTH
) (
   input  wire logic        CLK,
   input  wire logic        RST_N,
   regfile_loader_if.slave  bus
);

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_done;

   logic w_in_load;
   logic w_in_pad;
   logic w_accept;
   logic w_last_slot;

   assign w_in_load   = (r_state == ST_LOAD);
`ifdef REGFILE_LOADER_ZERO_PAD_EN
   assign w_in_pad    = (r_state == ST_PAD);
`else
   assign w_in_pad    = 1'b0;
`endif
   assign w_accept    = w_in_load & bus.s_valid;
   // DEPTH-1 is all ones, so the final slot is detected with a reduction AND.
   assign w_last_slot = &r_wr_ptr;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state  <= ST_IDLE;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  r_state  <= ST_LOAD;
                  r_wr_ptr <= '0;
                  r_count  <= '0;
                  r_done   <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (w_accept) begin
                  r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                  r_count  <= r_count + (ADDR_WIDTH+1)'(1);
                  if (w_last_slot) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else if (bus.s_last) begin
`ifdef REGFILE_LOADER_ZERO_PAD_EN
                     r_state <= ST_PAD;
`else
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
`endif
                  end
               end
            end
`ifdef REGFILE_LOADER_ZERO_PAD_EN
            ST_PAD: begin
               r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
               if (w_last_slot) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Storage port is owned by the loader only while filling; otherwise the consumer drives the address.
   assign bus.s_ready    = w_in_load;
   assign bus.busy       = w_in_load | w_in_pad;
   assign bus.done       = r_done;
   assign bus.count      = r_count;
   assign bus.rf_we      = w_accept | w_in_pad;
   assign bus.rf_addr    = (w_in_load | w_in_pad) ? r_wr_ptr : bus.rd_addr;
   assign bus.rf_wr_data = w_in_load ? bus.s_data : '0;

endmodule

`default_nettype wire
